// File: rtl/pl_io_port_if.sv
// Memory-mapped bus between the CPU MEM stage (master) and the pl_io_port
// responder (slave): address, store/load strobes, load return and region hit.
interface pl_io_port_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        rvalid;
  logic        hit;

  modport master (output addr, wdata, we, re, input  rdata, rvalid, hit);
  modport slave  (input  addr, wdata, we, re, output rdata, rvalid, hit);
endinterface

// File: rtl/pl_io_port.sv
// pl_io_port: memory-mapped I/O responder for the CPU data-memory stage.
// Owns output registers OUT0..OUT3 and synchronizes and change-flags inputs
// IN0..IN3, with a maskable change interrupt.
// Optional feature macro IO_EDGE_COUNT_EN: per-input 16-bit saturating change
// counters CNT0..CNT3 at offsets 0x30-0x3C; when undefined they read as 0.
module pl_io_port #(
  parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
  parameter int          SYNC_STAGES = 2,             // legal range 2..4
  parameter logic [31:0] OTP_RESET   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  pl_io_port_if.slave bus,
  input  logic [31:0] inp0,
  input  logic [31:0] inp1,
  input  logic [31:0] inp2,
  input  logic [31:0] inp3,
  output logic [31:0] otp0,
  output logic [31:0] otp1,
  output logic [31:0] otp2,
  output logic [31:0] otp3,
  output logic        irq
);

  // Change detection is armed only once both the last stage and its previous
  // value hold genuine post-reset samples.
  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);
  localparam logic [5:0] W_STAT    = 6'h08;
  localparam logic [5:0] W_MASK    = 6'h09;

  logic [31:0] inp_w  [4];
  logic [31:0] sync_q [4][SYNC_STAGES];
  logic [31:0] prev_q [4];
  logic [31:0] otp_q  [4];
  logic [2:0]  warm_q;
  logic [3:0]  mask_q;
  logic [3:0]  chg_q;
  logic [3:0]  chg_set;
  logic [3:0]  stat_clr;
  logic [5:0]  word;
  logic        hit_w;
  logic        wr_acc;
  logic        rd_acc;
  logic [31:0] rd_val;
  logic [1:0]  unused_addr_bits;
`ifdef IO_EDGE_COUNT_EN
  logic [15:0] cnt_q [4];
`endif

  assign inp_w[0] = inp0;
  assign inp_w[1] = inp1;
  assign inp_w[2] = inp2;
  assign inp_w[3] = inp3;

  assign hit_w            = (bus.addr[31:8] == BASE_ADDR[31:8]);
  assign bus.hit          = hit_w;
  assign word             = bus.addr[7:2];
  assign unused_addr_bits = bus.addr[1:0];
  assign wr_acc           = bus.we && hit_w;
  assign rd_acc           = bus.re && hit_w;

  assign otp0 = otp_q[0];
  assign otp1 = otp_q[1];
  assign otp2 = otp_q[2];
  assign otp3 = otp_q[3];

  // Input synchronizer chains, previous last-stage value and warm-up counter.
  always_ff @(posedge clock) begin
    // NOTE: the synchronizer array is an explicit flop chain, not a RAM, so it is reset like any other register.
    if (reset) begin
      warm_q <= '0;
      for (int n = 0; n < 4; n++) begin
        prev_q[n] <= '0;
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[n][s] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's old value on the same edge.
      if (warm_q != WARM_DONE) warm_q <= warm_q + 3'd1;
      for (int n = 0; n < 4; n++) begin
        sync_q[n][0] <= inp_w[n];
        for (int s = 1; s < SYNC_STAGES; s++) sync_q[n][s] <= sync_q[n][s-1];
        prev_q[n] <= sync_q[n][SYNC_STAGES-1];
      end
    end
  end

  // Per-port change condition: last stage differs from its previous value.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    chg_set = '0;
    for (int n = 0; n < 4; n++)
      chg_set[n] = (warm_q == WARM_DONE) && (sync_q[n][SYNC_STAGES-1] != prev_q[n]);
  end

  // STAT clear mask: bits returned by a STAT read plus write-1-to-clear bits.
  always_comb begin
    stat_clr = '0;
    if (rd_acc && word == W_STAT) stat_clr = chg_q;
    if (wr_acc && word == W_STAT) stat_clr = stat_clr | bus.wdata[3:0];
  end

  // Read mux over the pre-edge register values.
  always_comb begin
    rd_val = '0;
    case (word[5:2])
      4'd0: rd_val = sync_q[word[1:0]][SYNC_STAGES-1];
      4'd1: rd_val = otp_q[word[1:0]];
      4'd2: begin
        if (word == W_STAT)      rd_val = {28'b0, chg_q};
        else if (word == W_MASK) rd_val = {28'b0, mask_q};
      end
`ifdef IO_EDGE_COUNT_EN
      4'd3: rd_val = {16'b0, cnt_q[word[1:0]]};
`endif
      default: rd_val = '0;
    endcase
  end

  // Output ports, mask, sticky change flags (set beats clear) and interrupt.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) otp_q[n] <= OTP_RESET;
      mask_q <= '0;
      chg_q  <= '0;
      irq    <= 1'b0;
    end else begin
      irq   <= |(chg_q & mask_q);
      chg_q <= (chg_q & ~stat_clr) | chg_set;
      if (wr_acc) begin
        if (word[5:2] == 4'd1) otp_q[word[1:0]] <= bus.wdata;
        if (word == W_MASK)    mask_q <= bus.wdata[3:0];
      end
    end
  end

  // Registered load return; rdata holds between accepted loads.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      bus.rvalid <= rd_acc;
      if (rd_acc) bus.rdata <= rd_val;
    end
  end

`ifdef IO_EDGE_COUNT_EN
  // Saturating change counters; a write clears, keeping a same-cycle increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (wr_acc && word == {4'd3, 2'(n)}) cnt_q[n] <= {15'b0, chg_set[n]};
        else if (chg_set[n] && cnt_q[n] != 16'hFFFF) cnt_q[n] <= cnt_q[n] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pl_io_port.sv
// Self-checking bench for pl_io_port: directed scenarios plus randomized
// bus/input traffic compared every cycle against a queue-based reference model.
module tb_pl_io_port;
  localparam int S = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inp_v [4];
  logic [31:0] otp0, otp1, otp2, otp3;
  logic        irq;

  pl_io_port_if bus_if ();

  pl_io_port #(.SYNC_STAGES(S)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if),
    .inp0  (inp_v[0]),
    .inp1  (inp_v[1]),
    .inp2  (inp_v[2]),
    .inp3  (inp_v[3]),
    .otp0  (otp0),
    .otp1  (otp1),
    .otp2  (otp2),
    .otp3  (otp3),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: each input's history is a queue of the values seen at
  // every post-reset edge; the visible IN value is the one from S edges back.
  logic [31:0] hist [4][$];
  logic [31:0] m_otp [4];
  logic [15:0] m_cnt [4];
  logic [3:0]  m_mask, m_chg;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_irq;

  function automatic logic [31:0] m_in(input int n);
    int len;
    len = hist[n].size();
    return (len >= S) ? hist[n][len-S] : 32'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    logic [31:0] v;
    v = 32'h0;
    if (off <= 8'h0C)                    v = m_in(int'(off[3:2]));
    else if (off >= 8'h10 && off <= 8'h1C) v = m_otp[off[3:2]];
    else if (off == 8'h20)               v = {28'b0, m_chg};
    else if (off == 8'h24)               v = {28'b0, m_mask};
`ifdef IO_EDGE_COUNT_EN
    else if (off >= 8'h30 && off <= 8'h3C) v = {16'b0, m_cnt[off[3:2]]};
`endif
    return v;
  endfunction

  task automatic model_step();
    logic       hit_m, rd_m, wr_m;
    logic [7:0] off;
    logic [3:0] set, clr;
    logic [31:0] rv;
    int len;
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        m_otp[n] = 32'h0;
        m_cnt[n] = 16'h0;
        hist[n].delete();
      end
      m_mask = 4'h0; m_chg = 4'h0; m_rdata = 32'h0; m_rvalid = 1'b0; m_irq = 1'b0;
      return;
    end
    hit_m = (bus_if.addr[31:8] == 24'hC0_0000);
    off   = bus_if.addr[7:0] & 8'hFC;
    rd_m  = bus_if.re && hit_m;
    wr_m  = bus_if.we && hit_m;
    for (int n = 0; n < 4; n++) begin
      len    = hist[n].size();
      set[n] = (len >= S + 1) && (hist[n][len-S] != hist[n][len-S-1]);
    end
    rv       = m_read(off);
    m_irq    = |(m_chg & m_mask);
    m_rvalid = rd_m;
    if (rd_m) m_rdata = rv;
    clr = 4'h0;
    if (rd_m && off == 8'h20) clr = clr | m_chg;
    if (wr_m && off == 8'h20) clr = clr | bus_if.wdata[3:0];
    m_chg = (m_chg & ~clr) | set;
    if (wr_m && off >= 8'h10 && off <= 8'h1C) m_otp[off[3:2]] = bus_if.wdata;
    if (wr_m && off == 8'h24) m_mask = bus_if.wdata[3:0];
`ifdef IO_EDGE_COUNT_EN
    for (int n = 0; n < 4; n++) begin
      if (wr_m && off == 8'h30 + 8'(n * 4)) m_cnt[n] = set[n] ? 16'd1 : 16'd0;
      else if (set[n] && m_cnt[n] != 16'hFFFF) m_cnt[n] = m_cnt[n] + 16'd1;
    end
`endif
    for (int n = 0; n < 4; n++) begin
      hist[n].push_back(inp_v[n]);
      if (hist[n].size() > S + 2) void'(hist[n].pop_front());
    end
  endtask

  // One clock: check hit before the edge, advance the model, check after it.
  task automatic do_cycle();
    #1;
    check("hit", {31'b0, bus_if.hit}, {31'b0, bus_if.addr[31:8] == 24'hC0_0000});
    model_step();
    @(posedge clock);
    #1;
    check("rdata",  bus_if.rdata, m_rdata);
    check("rvalid", {31'b0, bus_if.rvalid}, {31'b0, m_rvalid});
    check("irq",    {31'b0, irq}, {31'b0, m_irq});
    check("otp0",   otp0, m_otp[0]);
    check("otp1",   otp1, m_otp[1]);
    check("otp2",   otp2, m_otp[2]);
    check("otp3",   otp3, m_otp[3]);
  endtask

  task automatic idle();
    bus_if.we = 1'b0; bus_if.re = 1'b0;
    do_cycle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.addr = a; bus_if.wdata = d; bus_if.we = 1'b1; bus_if.re = 1'b0;
    do_cycle();
    bus_if.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus_if.addr = a; bus_if.we = 1'b0; bus_if.re = 1'b1;
    do_cycle();
    bus_if.re = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus_if.addr = 32'hC000_0000; bus_if.wdata = 32'h0; bus_if.we = 1'b0; bus_if.re = 1'b0;
    inp_v[0] = 32'h0000_1000; inp_v[1] = 32'h5555_AAAA;
    inp_v[2] = 32'h8888_8888; inp_v[3] = 32'h0F0F_0F0F;
    repeat (2) do_cycle();
    reset = 1'b0;
    repeat (S + 3) idle();

    // Reset clears a previously written output register.
    wr(32'hC000_0010, 32'h0000_1234);
    check("otp0_pre_reset", otp0, 32'h0000_1234);
    reset = 1'b1;
    do_cycle();
    check("rst_otp0", otp0, 32'h0); check("rst_otp1", otp1, 32'h0);
    check("rst_otp2", otp2, 32'h0); check("rst_otp3", otp3, 32'h0);
    check("rst_rvalid", {31'b0, bus_if.rvalid}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    repeat (S + 3) idle();

    // Store then load OUT1.
    wr(32'hC000_0014, 32'hDEAD_BEEF);
    check("otp1_store", otp1, 32'hDEAD_BEEF);
    rd(32'hC000_0014);
    check("out1_rvalid", {31'b0, bus_if.rvalid}, 32'h1);
    check("out1_rdata", bus_if.rdata, 32'hDEAD_BEEF);
    idle();
    check("rvalid_drop", {31'b0, bus_if.rvalid}, 32'h0);
    check("rdata_hold", bus_if.rdata, 32'hDEAD_BEEF);

    // inp2 change: flag after S+1 edges, irq one edge later, clear on read.
    wr(32'hC000_0020, 32'hF);
    wr(32'hC000_0024, 32'h4);
    inp_v[2] = 32'h8888_8889;
    for (int k = 0; k < S + 1; k++) begin
      idle();
      check("irq_before", {31'b0, irq}, 32'h0);
    end
    rd(32'hC000_0020);
    check("irq_after", {31'b0, irq}, 32'h1);
    check("stat_rd", bus_if.rdata, 32'h4);
    idle();
    check("irq_cleared", {31'b0, irq}, 32'h0);
    rd(32'hC000_0020);
    check("stat_empty", bus_if.rdata, 32'h0);

    // inp0 flag sets on the same edge as a STAT read: set wins.
    wr(32'hC000_0024, 32'h5);
    inp_v[0] = inp_v[0] ^ 32'h1;
    repeat (S) idle();
    rd(32'hC000_0020);
    check("stat_race_ret", bus_if.rdata, 32'h0);
    idle();
    check("stat_race_irq", {31'b0, irq}, 32'h1);
    wr(32'hC000_0020, 32'h1);
    idle();
    check("w1c_irq", {31'b0, irq}, 32'h0);
    rd(32'hC000_0020);
    check("w1c_stat", bus_if.rdata, 32'h0);

    // Unmapped offset, out-of-region store and load, same-cycle read+write.
    wr(32'hC000_0010, 32'hA5A5_A5A5);
    rd(32'hC000_0040);
    check("unmapped_rd", bus_if.rdata, 32'h0);
    bus_if.addr = 32'h0000_0010; bus_if.wdata = 32'h1111_1111; bus_if.we = 1'b1;
    #1 check("miss_hit", {31'b0, bus_if.hit}, 32'h0);
    do_cycle();
    bus_if.we = 1'b0;
    check("miss_otp0", otp0, 32'hA5A5_A5A5);
    rd(32'hC000_0010);
    rd(32'h0000_0000);
    check("miss_rvalid", {31'b0, bus_if.rvalid}, 32'h0);
    check("miss_rdata_hold", bus_if.rdata, 32'hA5A5_A5A5);
    wr(32'hC000_0018, 32'h1);
    bus_if.addr = 32'hC000_0018; bus_if.wdata = 32'h2; bus_if.we = 1'b1; bus_if.re = 1'b1;
    do_cycle();
    check("rw_old", bus_if.rdata, 32'h1);
    check("rw_new", otp2, 32'h2);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) bus_if.addr = $urandom;
      else bus_if.addr = 32'hC000_0000 | (32'($urandom_range(0, 17)) << 2) | 32'($urandom_range(0, 3));
      bus_if.wdata = $urandom;
      bus_if.we = ($urandom_range(0, 2) == 0);
      bus_if.re = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 5) == 0) begin
        int p;
        p = $urandom_range(0, 3);
        inp_v[p] = inp_v[p] ^ (32'h1 << $urandom_range(0, 31));
      end
      do_cycle();
    end
    idle();

`ifdef IO_EDGE_COUNT_EN
    // Saturation of CNT3 under continuous toggling, then clear by write.
    wr(32'hC000_003C, 32'h0);
    for (int i = 0; i < 70000; i++) begin
      inp_v[3] = ~inp_v[3];
      idle();
    end
    repeat (S + 2) idle();
    rd(32'hC000_003C);
    check("cnt3_sat", bus_if.rdata, 32'h0000_FFFF);
    wr(32'hC000_003C, 32'h1234);
    rd(32'hC000_003C);
    check("cnt3_clear", bus_if.rdata, 32'h0);
`else
    rd(32'hC000_003C);
    check("cnt3_absent", bus_if.rdata, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
